// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch program-counter generator with prioritised redirects and pending buffer
//
// Purpose:
//    Produces the fetch PC at the head of IF. The PC advances by INC each
//    enabled cycle. A trap or branch redirect replaces it, and the trap has
//    priority. A stall holds the PC. Any redirect that arrives while stalled
//    is parked in a one-entry buffer and applied when the stall releases.
//    Redirect targets are aligned to IALIGN before use. A nonzero dropped bit
//    is reported on misalign_o for the cycle in which that PC is presented.
//
// Optional feature:
//    PCGEN_PERF_EN adds saturating redirect and stall counters.
//
// Ports:
//    clk, rst            clock (rising edge), synchronous active-high reset
//    en                  global clock enable, all state holds when 0
//    stall_i             hold PC, capture redirects into the pending buffer
//    br_valid_i/target   branch/jump redirect
//    trap_valid_i/target trap redirect (wins over branch)
//    pc_o, pc_plus_inc_o current fetch PC and pc_o + INC
//    pc_valid_o          PC valid for fetch
//    misalign_o          pc_o came from a misaligned target
//    redirect_pending_o  pending-redirect buffer occupied
//    perf_redirect_cnt_o, perf_stall_cnt_o (PCGEN_PERF_EN only)

module pc_gen_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              INC          = 4,
   parameter int              IALIGN       = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            stall_i,
   input  logic            br_valid_i,
   input  logic [XLEN-1:0] br_target_i,
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] trap_target_i,
`ifdef PCGEN_PERF_EN
   output logic [31:0]     perf_redirect_cnt_o,
   output logic [31:0]     perf_stall_cnt_o,
`endif
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus_inc_o,
   output logic            pc_valid_o,
   output logic            misalign_o,
   output logic            redirect_pending_o
);

   // Low target bits that must be zero for a legal instruction address.
   localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

   typedef enum logic {KIND_BRANCH = 1'b0, KIND_TRAP = 1'b1} kind_t;

   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic            mis_q, mis_d;
   logic            pend_q, pend_d;
   kind_t           kind_q, kind_d;
   logic [XLEN-1:0] ptgt_q, ptgt_d;
   logic            pmis_q, pmis_d;
   logic            redirect_load;
   logic            stall_count;

   logic [XLEN-1:0] pc_plus;
   logic [XLEN-1:0] trap_tgt, br_tgt;
   logic            trap_mis, br_mis;

   assign pc_plus  = pc_q + XLEN'(INC);
   assign trap_tgt = trap_target_i & ~ALIGN_MASK;
   assign trap_mis = |(trap_target_i & ALIGN_MASK);
   assign br_tgt   = br_target_i & ~ALIGN_MASK;
   assign br_mis   = |(br_target_i & ALIGN_MASK);

   always_comb begin
      pc_d          = pc_q;
      valid_d       = valid_q;
      mis_d         = mis_q;
      pend_d        = pend_q;
      kind_d        = kind_q;
      ptgt_d        = ptgt_q;
      pmis_d        = pmis_q;
      redirect_load = 1'b0;
      stall_count   = 1'b0;
      if (!valid_q) begin
         // First enabled edge out of reset only raises valid, so the first
         // fetch is at RESET_VECTOR.
         valid_d = 1'b1;
      end else if (stall_i) begin
         stall_count = 1'b1;
         mis_d       = 1'b0;
         if (trap_valid_i) begin
            pend_d = 1'b1;
            kind_d = KIND_TRAP;
            ptgt_d = trap_tgt;
            pmis_d = trap_mis;
         end else if (br_valid_i && !(pend_q && kind_q == KIND_TRAP)) begin
            // A parked trap must survive later branches.
            pend_d = 1'b1;
            kind_d = KIND_BRANCH;
            ptgt_d = br_tgt;
            pmis_d = br_mis;
         end
      end else begin
         // A live redirect supersedes any parked one, so the buffer always empties here.
         pend_d = 1'b0;
         if (trap_valid_i) begin
            pc_d          = trap_tgt;
            mis_d         = trap_mis;
            redirect_load = 1'b1;
         end else if (br_valid_i) begin
            pc_d          = br_tgt;
            mis_d         = br_mis;
            redirect_load = 1'b1;
         end else if (pend_q) begin
            pc_d          = ptgt_q;
            mis_d         = pmis_q;
            redirect_load = 1'b1;
         end else begin
            pc_d  = pc_plus;
            mis_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_VECTOR;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
         pend_q  <= 1'b0;
         kind_q  <= KIND_BRANCH;
         ptgt_q  <= '0;
         pmis_q  <= 1'b0;
      end else if (en) begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
         pend_q  <= pend_d;
         kind_q  <= kind_d;
         ptgt_q  <= ptgt_d;
         pmis_q  <= pmis_d;
      end
   end

`ifdef PCGEN_PERF_EN
   logic [31:0] rcnt_q, scnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt_q <= '0;
         scnt_q <= '0;
      end else if (en) begin
         if (redirect_load && rcnt_q != 32'hFFFF_FFFF) rcnt_q <= rcnt_q + 32'd1;
         if (stall_count && scnt_q != 32'hFFFF_FFFF)   scnt_q <= scnt_q + 32'd1;
      end
   end

   assign perf_redirect_cnt_o = rcnt_q;
   assign perf_stall_cnt_o    = scnt_q;
`else
   logic unused_perf;
   assign unused_perf = redirect_load ^ stall_count;
`endif

   assign pc_o               = pc_q;
   assign pc_plus_inc_o      = pc_plus;
   assign pc_valid_o         = valid_q;
   assign misalign_o         = mis_q;
   assign redirect_pending_o = pend_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - scoreboard bench for pc_gen_unit (IALIGN 32 and 16 instances)

module tb_pc_gen_unit;

   localparam logic [31:0] RV = 32'h0000_0100;

   logic        clk, rst, en, stall, br_v, trap_v;
   logic [31:0] br_t, trap_t;
   logic [31:0] pc_w [2];
   logic [31:0] pcp_w [2];
   logic        val_w [2];
   logic        mis_w [2];
   logic        pend_w [2];
`ifdef PCGEN_PERF_EN
   logic [31:0] rc_w [2];
   logic [31:0] sc_w [2];
`endif

   pc_gen_unit #(.XLEN(32), .RESET_VECTOR(RV), .INC(4), .IALIGN(32)) u_a32 (
      .clk(clk), .rst(rst), .en(en), .stall_i(stall),
      .br_valid_i(br_v), .br_target_i(br_t),
      .trap_valid_i(trap_v), .trap_target_i(trap_t),
`ifdef PCGEN_PERF_EN
      .perf_redirect_cnt_o(rc_w[0]), .perf_stall_cnt_o(sc_w[0]),
`endif
      .pc_o(pc_w[0]), .pc_plus_inc_o(pcp_w[0]), .pc_valid_o(val_w[0]),
      .misalign_o(mis_w[0]), .redirect_pending_o(pend_w[0])
   );

   pc_gen_unit #(.XLEN(32), .RESET_VECTOR(RV), .INC(4), .IALIGN(16)) u_a16 (
      .clk(clk), .rst(rst), .en(en), .stall_i(stall),
      .br_valid_i(br_v), .br_target_i(br_t),
      .trap_valid_i(trap_v), .trap_target_i(trap_t),
`ifdef PCGEN_PERF_EN
      .perf_redirect_cnt_o(rc_w[1]), .perf_stall_cnt_o(sc_w[1]),
`endif
      .pc_o(pc_w[1]), .pc_plus_inc_o(pcp_w[1]), .pc_valid_o(val_w[1]),
      .misalign_o(mis_w[1]), .redirect_pending_o(pend_w[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state: what the unit should hold after an edge.
   typedef struct {
      logic [31:0] pc;
      bit          valid, mis, pend, ptrap, pmis;
      logic [31:0] ptgt;
      int unsigned rc, sc;
   } mst_t;

   typedef struct {
      int                tag;
      logic [1:0][31:0]  pc;
      logic [1:0]        valid, mis, pend;
      logic [1:0][31:0]  rc, sc;
   } exp_t;

   mst_t ms [2];
   exp_t sb [$];
   int   edge_cnt = 0;
   int   vectors = 0;
   int   miscompares = 0;

   function automatic int unsigned sat(int unsigned x);
      return (x == 32'hFFFF_FFFF) ? x : x + 1;
   endfunction

   function automatic mst_t mnext(mst_t s, bit r, bit e, bit st, bit b, logic [31:0] bt,
                                  bit t, logic [31:0] tt, logic [31:0] am);
      mst_t        n;
      logic [31:0] raw, tgt;
      bit          mis, hit;
      n = s;
      if (r) begin
         n = '{default: 0};
         n.pc = RV;
         return n;
      end
      if (!e) return n;
      if (!s.valid) begin
         n.valid = 1;
         return n;
      end
      hit = t || b;
      raw = t ? tt : bt;
      mis = (raw & am) != 0;
      tgt = raw & ~am;
      if (st) begin
         n.sc  = sat(s.sc);
         n.mis = 0;
         if (hit && (t || !(s.pend && s.ptrap))) begin
            n.pend  = 1;
            n.ptrap = t;
            n.ptgt  = tgt;
            n.pmis  = mis;
         end
         return n;
      end
      n.pend = 0;
      if (hit) begin
         n.pc = tgt;  n.mis = mis;    n.rc = sat(s.rc);
      end else if (s.pend) begin
         n.pc = s.ptgt; n.mis = s.pmis; n.rc = sat(s.rc);
      end else begin
         n.pc = s.pc + 32'd4; n.mis = 0;
      end
      return n;
   endfunction

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic drv(input bit r, input bit e, input bit s, input bit b, input logic [31:0] bt,
                      input bit t, input logic [31:0] tt);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r; en = e; stall = s; br_v = b; br_t = bt; trap_v = t; trap_t = tt;
      x.tag = edge_cnt + 1;
      for (int k = 0; k < 2; k++) begin
         ms[k] = mnext(ms[k], r, e, s, b, bt, t, tt, (k == 0) ? 32'h3 : 32'h1);
         x.pc[k]    = ms[k].pc;
         x.valid[k] = ms[k].valid;
         x.mis[k]   = ms[k].mis;
         x.pend[k]  = ms[k].pend;
         x.rc[k]    = ms[k].rc;
         x.sc[k]    = ms[k].sc;
      end
      sb.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(0, 1, 0, 0, 32'h0, 0, 32'h0);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @edge %0d: got %h want %h", nm, edge_cnt, act, exp);
      end
   endtask

   // Monitor: compares every expected entry whose edge has occurred.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
            x = sb.pop_front();
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("pc[%0d]", k), pc_w[k], x.pc[k]);
               chk($sformatf("pc_plus_inc[%0d]", k), pcp_w[k], x.pc[k] + 32'd4);
               chk($sformatf("pc_valid[%0d]", k), {31'b0, val_w[k]}, {31'b0, x.valid[k]});
               chk($sformatf("misalign[%0d]", k), {31'b0, mis_w[k]}, {31'b0, x.mis[k]});
               chk($sformatf("pending[%0d]", k), {31'b0, pend_w[k]}, {31'b0, x.pend[k]});
`ifdef PCGEN_PERF_EN
               chk($sformatf("perf_redirect[%0d]", k), rc_w[k], x.rc[k]);
               chk($sformatf("perf_stall[%0d]", k), sc_w[k], x.sc[k]);
`endif
            end
         end
      end
   end

   initial begin
      bit          r, e, s, b, t;
      logic [31:0] bt, tt;
      rst = 1; en = 1; stall = 0; br_v = 0; trap_v = 0; br_t = '0; trap_t = '0;

      // Reset and free-run sequencing
      drv(1, 1, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 0, 0, 0, 0);
      idle(4);

      // Priority: trap beats branch at pc 0x200
      drv(0, 1, 0, 1, 32'h200, 0, 0);
      drv(0, 1, 0, 1, 32'h300, 1, 32'h8000);
      idle(2);

      // Stall capture at pc 0x40: branch, trap, branch (trap must survive)
      drv(0, 1, 0, 1, 32'h40, 0, 0);
      drv(0, 1, 1, 1, 32'h500, 0, 0);
      drv(0, 1, 1, 0, 0, 1, 32'h900);
      drv(0, 1, 1, 1, 32'h600, 0, 0);
      idle(3);

      // Misaligned branch target
      drv(0, 1, 0, 1, 32'h1003, 0, 0);
      idle(2);

      // Wrap across 2^32 with an enable gap
      drv(0, 1, 0, 1, 32'hFFFF_FFF8, 0, 0);
      idle(1);
      drv(0, 0, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // Reset while a redirect is pending
      drv(0, 1, 1, 1, 32'h700, 0, 0);
      drv(0, 1, 1, 0, 0, 0, 0);
      drv(1, 1, 1, 0, 0, 0, 0);
      idle(3);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         r  = ($urandom_range(0, 59) == 0);
         e  = ($urandom_range(0, 9) != 0);
         s  = ($urandom_range(0, 9) < 3);
         b  = e && ($urandom_range(0, 9) < 2);
         t  = e && ($urandom_range(0, 9) == 0);
         bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         tt = $urandom;
         drv(r, e, s, b, bt, t, tt);
      end
      idle(2);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised fetch program-counter generator for the rv32im pipeline; successor to the single-select PC register.
- Adds the following over that register:
  - configurable XLEN, reset vector, increment and instruction alignment;
  - two prioritised redirect sources (trap, branch);
  - a stall input that holds the PC;
  - a one-entry pending-redirect buffer, so a redirect that arrives during a stall is not lost;
  - misaligned-target detection.
- Sits at the head of IF and drives the instruction-memory address and the IF/ID PC.

Parameters:
- XLEN, 32, datapath width of all PC/target signals.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INC, 4, sequential increment added to the PC.
- IALIGN, 32, instruction alignment in bits. Legal values: 32 (mask bits [1:0]) or 16 (mask bit [0]).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  global clock enable; when 0 all state holds.
- stall_i  input  1  hold PC (IF/ID back-pressure).
- br_valid_i  input  1  branch/jump redirect request.
- br_target_i  input  XLEN  branch/jump target.
- trap_valid_i  input  1  trap/exception redirect request.
- trap_target_i  input  XLEN  trap vector.
- pc_o  output  XLEN  current fetch PC.
- pc_plus_inc_o  output  XLEN  pc_o + INC, combinational.
- pc_valid_o  output  1  PC valid for fetch.
- misalign_o  output  1  the PC just loaded came from a misaligned target.
- redirect_pending_o  output  1  pending-redirect buffer occupied.

Behaviour:
- Reset:
  - rst is synchronous, active-high, clock clk. It acts regardless of en.
  - Reset values: pc_o=RESET_VECTOR, pc_valid_o=0, misalign_o=0, redirect_pending_o=0, pending kind/target cleared.
- pc_valid_o:
  - Rises on the first en=1 edge after rst deasserts; stays 1 until the next reset.
  - pc_o stays RESET_VECTOR on that edge (no increment), so the first fetch is at RESET_VECTOR.
- en=0: all registers hold. Redirect inputs are ignored; upstream must not assert them while en=0.
- Next-PC selection on an en=1, rst=0, pc_valid_o=1 edge, with stall_i=0, highest priority first:
  - (1) trap_valid_i: pc_o <= trap_target_i.
  - (2) br_valid_i: pc_o <= br_target_i.
  - (3) pending buffer occupied: pc_o <= pending target.
  - (4) otherwise pc_o <= pc_o + INC.
  - Any of (1)-(3) clears the pending buffer; a live redirect supersedes an older pending one.
- Stall (stall_i=1): pc_o holds, and redirect inputs are captured into the pending buffer:
  - Trap: always writes the buffer (kind=TRAP).
  - Branch: writes the buffer only if it is empty or holds a BRANCH. A pending TRAP is never overwritten by a branch.
  - Trap and branch in the same cycle: trap captured.
- Pending buffer exit:
  - Buffer applies on the first edge with stall_i=0 and no live redirect.
  - redirect_pending_o = buffer occupied (registered).
- Alignment:
  - All redirect targets are masked to IALIGN before loading (low 2 bits cleared for 32, bit 0 for 16).
  - misalign_o is registered. It is 1 for exactly the cycle in which pc_o holds a PC loaded from a target whose masked bits were nonzero; it is 0 otherwise, including during stall hold cycles.
  - Misalignment is evaluated at capture time and carried through the pending buffer.
- Arithmetic: pc_o + INC is modulo 2^XLEN (wraps, no flag).
- Reset mid-stall or with a pending redirect: the buffer is discarded and the PC returns to RESET_VECTOR.

Optional Feature:
- Macro PCGEN_PERF_EN.
- Defined: adds outputs perf_redirect_cnt_o [31:0] and perf_stall_cnt_o [31:0].
  - Both are cleared by rst and saturate at 32'hFFFF_FFFF.
  - perf_redirect_cnt_o increments on each edge where pc_o loads a redirect: live, or from the pending buffer.
  - perf_stall_cnt_o increments on each en=1 edge with stall_i=1 and pc_valid_o=1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset and sequencing: rst for 2 cycles, then free-run with XLEN=32, RESET_VECTOR=0x100.
  - Required: pc_o = 0x100, 0x100 (first valid), 0x104, 0x108; pc_plus_inc_o = pc_o + 4.
- Priority: at pc_o=0x200, assert trap_valid_i (target 0x8000) and br_valid_i (target 0x300) together.
  - Required: next pc_o = 0x8000, then 0x8004.
- Stall capture: stall_i=1 for 3 cycles at pc_o=0x40; br_valid_i with target 0x500 in stall cycle 1; trap_valid_i with target 0x900 in cycle 2; br_valid_i with target 0x600 in cycle 3.
  - Required: pc_o holds 0x40 throughout; redirect_pending_o=1.
  - After stall release: pc_o = 0x900 and redirect_pending_o = 0.
- Misalignment: br_valid_i with target 0x1003, IALIGN=32.
  - Required: pc_o = 0x1000 and misalign_o = 1 for exactly that cycle; next pc_o = 0x1004 with misalign_o = 0.
  - With IALIGN=16: target 0x1003 gives pc_o = 0x1002.
- Wrap and enable: pc_o = 0xFFFF_FFFC, then en = 0 for 2 cycles, then en = 1.
  - Required: pc_o holds 0xFFFF_FFFC while en=0, then becomes 0x0000_0000.
- Reset with pending redirect: rst asserted while redirect_pending_o=1.
  - Required: pc_o = RESET_VECTOR and redirect_pending_o = 0.
  - With PCGEN_PERF_EN defined: both counters read 0.
